// File: rtl/window_scan_ctrl.sv
// Raster-scan sequencer feeding a 3x3 window generator: issues pixel reads in raster order,
// realigns column/row tags to the memory read latency and flags pixels that close an interior window.
module window_scan_ctrl #(
  parameter int IMG_W   = 200,
  parameter int IMG_H   = 200,
  parameter int ADDR_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hold,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              shift_en,
  output logic [15:0]       pix_col,
  output logic [15:0]       pix_row,
  output logic              win_valid,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [15:0]       LAST_COL  = 16'(IMG_W - 1);
  localparam logic [2:0]        LAST_DRN  = 3'(MEM_LAT - 1);
  localparam int                TAIL      = MEM_LAT - 1;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       col;
  logic [15:0]       row;
  logic [2:0]        drain_cnt;

  // latency-matching pipeline: stage 0 holds the tag of the read issued last cycle
  logic              vld_p [MEM_LAT];
  logic [15:0]       col_p [MEM_LAT];
  logic [15:0]       row_p [MEM_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      col       <= '0;
      row       <= '0;
      drain_cnt <= '0;
      for (int i = 0; i < MEM_LAT; i++) begin
        vld_p[i] <= 1'b0;
        col_p[i] <= '0;
        row_p[i] <= '0;
      end
    end else begin
      // a start coincident with hold still enters SCAN; only the first read waits
      if (state == IDLE) begin
        if (start) begin
          state <= SCAN;
          addr  <= '0;
          col   <= '0;
          row   <= '0;
        end
      end
      if (!hold) begin
        vld_p[0] <= rd_en;
        col_p[0] <= col;
        row_p[0] <= row;
        for (int i = 1; i < MEM_LAT; i++) begin
          vld_p[i] <= vld_p[i-1];
          col_p[i] <= col_p[i-1];
          row_p[i] <= row_p[i-1];
        end
        case (state)
          SCAN: begin
            if (addr == LAST_ADDR) begin
              state     <= DRAIN;
              drain_cnt <= '0;
            end else begin
              addr <= addr + ADDR_W'(1);
              if (col == LAST_COL) begin
                col <= '0;
                row <= row + 16'd1;
              end else begin
                col <= col + 16'd1;
              end
            end
          end
          DRAIN: begin
            if (drain_cnt == LAST_DRN) state <= DONE;
            else drain_cnt <= drain_cnt + 3'd1;
          end
          DONE:    state <= IDLE;
          default: ;
        endcase
      end
    end
  end

  // stream outputs: hold gates strobes combinationally so nothing moves while stalled
  assign rd_en      = (state == SCAN) && !hold;
  assign rd_addr    = addr;
  assign shift_en   = vld_p[TAIL] && !hold;
  assign pix_col    = col_p[TAIL];
  assign pix_row    = row_p[TAIL];
  assign win_valid  = shift_en && (pix_row >= 16'd2) && (pix_col >= 16'd2);
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE) && !hold;

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Directed bench for window_scan_ctrl: small 4x3/3x3 frames checked cycle by cycle
// and a full default-size frame checked by counts and raster order.
module tb_window_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // instance a: 4x3, latency 1
  logic a_rst = 1'b1, a_start = 1'b0, a_hold = 1'b0;
  logic a_rd_en, a_shift_en, a_win_valid, a_busy, a_frame_done;
  logic [15:0] a_rd_addr, a_pix_col, a_pix_row;
  window_scan_ctrl #(.IMG_W(4), .IMG_H(3), .ADDR_W(16), .MEM_LAT(1)) dut_a (
    .clk(clk), .rst(a_rst), .start(a_start), .hold(a_hold),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .shift_en(a_shift_en),
    .pix_col(a_pix_col), .pix_row(a_pix_row), .win_valid(a_win_valid),
    .busy(a_busy), .frame_done(a_frame_done));

  // instance b: 3x3, latency 3
  logic b_rst = 1'b1, b_start = 1'b0, b_hold = 1'b0;
  logic b_rd_en, b_shift_en, b_win_valid, b_busy, b_frame_done;
  logic [15:0] b_rd_addr, b_pix_col, b_pix_row;
  window_scan_ctrl #(.IMG_W(3), .IMG_H(3), .ADDR_W(16), .MEM_LAT(3)) dut_b (
    .clk(clk), .rst(b_rst), .start(b_start), .hold(b_hold),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .shift_en(b_shift_en),
    .pix_col(b_pix_col), .pix_row(b_pix_row), .win_valid(b_win_valid),
    .busy(b_busy), .frame_done(b_frame_done));

  // instance c: default 200x200, latency 1
  logic c_rst = 1'b1, c_start = 1'b0, c_hold = 1'b0;
  logic c_rd_en, c_shift_en, c_win_valid, c_busy, c_frame_done;
  logic [15:0] c_rd_addr, c_pix_col, c_pix_row;
  window_scan_ctrl dut_c (
    .clk(clk), .rst(c_rst), .start(c_start), .hold(c_hold),
    .rd_en(c_rd_en), .rd_addr(c_rd_addr), .shift_en(c_shift_en),
    .pix_col(c_pix_col), .pix_row(c_pix_row), .win_valid(c_win_valid),
    .busy(c_busy), .frame_done(c_frame_done));

  task automatic chk_a_zero(input string tag);
    chk({tag, ".rd_en"},      a_rd_en,      0);
    chk({tag, ".rd_addr"},    a_rd_addr,    0);
    chk({tag, ".shift_en"},   a_shift_en,   0);
    chk({tag, ".pix_col"},    a_pix_col,    0);
    chk({tag, ".pix_row"},    a_pix_row,    0);
    chk({tag, ".win_valid"},  a_win_valid,  0);
    chk({tag, ".busy"},       a_busy,       0);
    chk({tag, ".frame_done"}, a_frame_done, 0);
  endtask

  initial begin
    int done_cnt;
    int n_sh, n_wv, n_fd, order_err;
    bit e_rd, e_sh;
    int e_addr, e_pix;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk_a_zero("rst");
    chk("rst.b_busy", b_busy, 0);
    chk("rst.b_shift_en", b_shift_en, 0);
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;

    // T1: plain 4x3 frame
    for (int c = 0; c <= 16; c++) begin
      @(negedge clk);
      a_start = (c == 0); a_hold = 1'b0;
      #1;
      e_rd = (c >= 1 && c <= 12);
      e_sh = (c >= 2 && c <= 13);
      chk($sformatf("t1.rd_en@%0d", c), a_rd_en, e_rd);
      if (e_rd) chk($sformatf("t1.rd_addr@%0d", c), a_rd_addr, c - 1);
      chk($sformatf("t1.shift_en@%0d", c), a_shift_en, e_sh);
      if (e_sh) begin
        chk($sformatf("t1.pix_col@%0d", c), a_pix_col, (c - 2) % 4);
        chk($sformatf("t1.pix_row@%0d", c), a_pix_row, (c - 2) / 4);
      end
      chk($sformatf("t1.win_valid@%0d", c), a_win_valid, (c == 12 || c == 13));
      chk($sformatf("t1.busy@%0d", c), a_busy, (c >= 1 && c <= 14));
      chk($sformatf("t1.frame_done@%0d", c), a_frame_done, (c == 14));
    end

    // T2: hold on cycles 5..7
    for (int c = 0; c <= 19; c++) begin
      @(negedge clk);
      a_start = (c == 0); a_hold = (c >= 5 && c <= 7);
      #1;
      e_rd = (c >= 1 && c <= 4) || (c >= 8 && c <= 15);
      e_addr = (c <= 4) ? c - 1 : c - 4;
      e_sh = (c >= 2 && c <= 4) || (c >= 8 && c <= 16);
      e_pix = (c <= 4) ? c - 2 : c - 5;
      chk($sformatf("t2.rd_en@%0d", c), a_rd_en, e_rd);
      if (e_rd) chk($sformatf("t2.rd_addr@%0d", c), a_rd_addr, e_addr);
      chk($sformatf("t2.shift_en@%0d", c), a_shift_en, e_sh);
      if (e_sh) chk($sformatf("t2.pix@%0d", c), 32'(a_pix_row) * 4 + 32'(a_pix_col), e_pix);
      chk($sformatf("t2.win_valid@%0d", c), a_win_valid, (c == 15 || c == 16));
      chk($sformatf("t2.frame_done@%0d", c), a_frame_done, (c == 17));
    end
    a_hold = 1'b0;

    // T3: 3x3 with latency 3
    for (int c = 0; c <= 15; c++) begin
      @(negedge clk);
      b_start = (c == 0);
      #1;
      e_rd = (c >= 1 && c <= 9);
      e_sh = (c >= 4 && c <= 12);
      chk($sformatf("t3.rd_en@%0d", c), b_rd_en, e_rd);
      if (e_rd) chk($sformatf("t3.rd_addr@%0d", c), b_rd_addr, c - 1);
      chk($sformatf("t3.shift_en@%0d", c), b_shift_en, e_sh);
      if (e_sh) begin
        chk($sformatf("t3.pix_col@%0d", c), b_pix_col, (c - 4) % 3);
        chk($sformatf("t3.pix_row@%0d", c), b_pix_row, (c - 4) / 3);
      end
      chk($sformatf("t3.win_valid@%0d", c), b_win_valid, (c == 12));
      chk($sformatf("t3.busy@%0d", c), b_busy, (c >= 1 && c <= 13));
      chk($sformatf("t3.frame_done@%0d", c), b_frame_done, (c == 13));
    end

    // T4: reset mid-frame at addr 5, then restart
    done_cnt = 0;
    for (int c = 0; c <= 24; c++) begin
      @(negedge clk);
      a_start = (c == 0 || c == 8); a_rst = (c == 6);
      #1;
      if (c == 6) chk("t4.rd_addr@6", a_rd_addr, 5);
      if (c == 7) chk_a_zero("t4.after_rst");
      if (c == 9)  begin chk("t4.rd_en@9", a_rd_en, 1); chk("t4.rd_addr@9", a_rd_addr, 0); end
      if (c == 10) chk("t4.rd_addr@10", a_rd_addr, 1);
      if (c == 22) chk("t4.frame_done@22", a_frame_done, 1);
      if (c >= 7 && a_frame_done) done_cnt++;
    end
    a_rst = 1'b0;
    chk("t4.done_count", done_cnt, 1);

    // T5: start pulses in SCAN, DRAIN and DONE are ignored
    done_cnt = 0;
    for (int c = 0; c <= 30; c++) begin
      @(negedge clk);
      a_start = (c == 0 || c == 5 || c == 13 || c == 14);
      #1;
      if (c == 6) chk("t5.rd_addr@6", a_rd_addr, 5);
      if (c == 16) chk("t5.busy@16", a_busy, 0);
      if (c == 30) chk("t5.busy@30", a_busy, 0);
      if (a_frame_done) done_cnt++;
    end
    chk("t5.done_count", done_cnt, 1);

    // T7: start with hold in IDLE, plus hold during DONE
    for (int c = 0; c <= 18; c++) begin
      @(negedge clk);
      a_start = (c == 0); a_hold = (c == 0 || c == 1 || c == 15);
      #1;
      if (c == 1)  begin chk("t7.busy@1", a_busy, 1); chk("t7.rd_en@1", a_rd_en, 0); end
      if (c == 2)  begin chk("t7.rd_en@2", a_rd_en, 1); chk("t7.rd_addr@2", a_rd_addr, 0); end
      if (c == 13) chk("t7.rd_addr@13", a_rd_addr, 11);
      if (c == 15) begin chk("t7.frame_done@15", a_frame_done, 0); chk("t7.busy@15", a_busy, 1); end
      if (c == 16) chk("t7.frame_done@16", a_frame_done, 1);
      if (c == 17) chk("t7.busy@17", a_busy, 0);
    end
    a_hold = 1'b0; a_start = 1'b0;

    // T6: full default frame
    n_sh = 0; n_wv = 0; n_fd = 0; order_err = 0;
    for (int c = 0; c <= 40005; c++) begin
      @(negedge clk);
      c_start = (c == 0);
      #1;
      if (c_shift_en) begin
        if (32'(c_pix_row) * 200 + 32'(c_pix_col) != n_sh) order_err++;
        n_sh++;
      end
      if (c_win_valid) n_wv++;
      if (c_frame_done) n_fd++;
    end
    chk("t6.shift_count", n_sh, 40000);
    chk("t6.win_count", n_wv, 198 * 198);
    chk("t6.done_count", n_fd, 1);
    chk("t6.order_err", order_err, 0);
    chk("t6.busy_end", c_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
